// File: rtl/color_threshold_ctrl.sv
// Colour-detection threshold controller: a shadow bank of six ctrl1/ctrl2 threshold sets
// that is copied to the active outputs atomically on the first start-of-frame after a commit.
// A forced apply happens if no SOF arrives within SOF_TIMEOUT cycles.
module color_threshold_ctrl #(
    parameter int unsigned SOF_TIMEOUT = 2500000,
    parameter int unsigned TO_WIDTH    = 22
) (
    input  logic         i_sysclk,
    input  logic         db_rstn,
    input  logic         i_sof,
    input  logic         i_pipe_flush,
    input  logic         i_wr_valid,
    output logic         o_wr_ready,
    input  logic [3:0]   i_wr_addr,
    input  logic [31:0]  i_wr_data,
    input  logic         i_commit,
    output logic         o_commit_pending,
    output logic         o_commit_done,
    output logic [95:0]  o_ctrl1,
    output logic [191:0] o_ctrl2,
    output logic         o_error,
    output logic         o_timeout
);

    // Colour k sits at the k-th slice; colour 0 (red) is the least significant.
    localparam logic [95:0] DEF_CTRL1 = {
        16'h00FF, 16'h8C73, 16'h4B41, 16'h0F3C, 16'h0A05, 16'h000A
    };
    localparam logic [191:0] DEF_CTRL2 = {
        32'h000A3232, 32'h32320A5A, 32'h32320A5A,
        32'h32320A5A, 32'h5A0A0A5A, 32'h32320A5A
    };
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(SOF_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StApply = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic [95:0]         sh_ctrl1_q;
    logic [191:0]        sh_ctrl2_q;
    logic                timeout_set;
    logic                apply;
    logic                wr_fire;
    logic                wr_addr_ok;

    assign o_wr_ready       = (state_q == StIdle);
    assign o_commit_pending = (state_q == StArmed) || (state_q == StApply);
    assign wr_fire          = i_wr_valid && o_wr_ready;
    assign wr_addr_ok       = (i_wr_addr < 4'd12);

    // Next-state logic: wait for an unflushed SOF or the timeout, then apply for one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        apply       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_commit) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                end
            end
            StArmed: begin
                // A flush freezes everything, including the timeout count.
                if (!i_pipe_flush) begin
                    if (i_sof) begin
                        state_d = StApply;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = StApply;
                        timeout_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StApply: begin
                state_d = StIdle;
                apply   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and sticky flag registers.
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            o_error       <= 1'b0;
            o_timeout     <= 1'b0;
            o_commit_done <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            o_commit_done <= apply;
            if (timeout_set) begin
                o_timeout <= 1'b1;
            end
            if (wr_fire && !wr_addr_ok) begin
                o_error <= 1'b1;
            end
        end
    end

    // Shadow bank: even address -> ctrl1 of colour addr/2, odd address -> ctrl2.
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            sh_ctrl1_q <= DEF_CTRL1;
            sh_ctrl2_q <= DEF_CTRL2;
        end else if (wr_fire && wr_addr_ok) begin
            for (int k = 0; k < 6; k++) begin
                if (i_wr_addr == 4'(2 * k)) begin
                    sh_ctrl1_q[16*k +: 16] <= i_wr_data[15:0];
                end
                if (i_wr_addr == 4'(2 * k + 1)) begin
                    sh_ctrl2_q[32*k +: 32] <= i_wr_data;
                end
            end
        end
    end

    // Active bank only changes as a whole, on leaving APPLY.
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            o_ctrl1 <= DEF_CTRL1;
            o_ctrl2 <= DEF_CTRL2;
        end else if (apply) begin
            o_ctrl1 <= sh_ctrl1_q;
            o_ctrl2 <= sh_ctrl2_q;
        end
    end

endmodule

// File: doc/color_threshold_ctrl.md
Name: color_threshold_ctrl

Overview:
Runtime configuration controller for the colour-detection thresholds.
- Accepts register writes into a shadow bank of six colour threshold sets: red, orange, yellow, green, blue, white.
- On a commit request, applies the whole bank atomically at the next start-of-frame, so that no frame is classified with mixed thresholds.
- Sits in the i_sysclk domain between the system controller / host write path and the colour-detection block's ctrl1/ctrl2 inputs.

Parameters:
SOF_TIMEOUT, 2500000, cycles to wait in ARMED for an SOF before a forced apply (20 ms at 125 MHz); minimum 2.
TO_WIDTH, 22, timeout counter width; must satisfy 2^TO_WIDTH > SOF_TIMEOUT.

Ports:
i_sysclk  in  1  system clock, 125 MHz; all logic on rising edge
db_rstn  in  1  reset, asynchronous, active-low; clock i_sysclk
i_sof  in  1  start-of-frame pulse, already synchronous to i_sysclk
i_pipe_flush  in  1  pipeline flush in progress
i_wr_valid  in  1  write request
o_wr_ready  out  1  write accept
i_wr_addr  in  4  register index
i_wr_data  in  32  write data
i_commit  in  1  single-cycle commit request
o_commit_pending  out  1  high while state is ARMED or APPLY
o_commit_done  out  1  one-cycle pulse when active thresholds update
o_ctrl1  out  96  active ctrl1 words; colour k at [16k+15:16k]
o_ctrl2  out  192  active ctrl2 words; colour k at [32k+31:32k]
o_error  out  1  sticky: write to invalid address
o_timeout  out  1  sticky: commit was forced by timeout

Behaviour:
- Colour index k: 0 red, 1 orange, 2 yellow, 3 green, 4 blue, 5 white.
- Address map:
  - addr 2k -> shadow ctrl1[k] <= i_wr_data[15:0]; upper bits ignored.
  - addr 2k+1 -> shadow ctrl2[k] <= i_wr_data.
  - addr 12..15 invalid.
- Reset and default values: shadow and active banks both load the defaults below.
  - ctrl1: 000A, 0A05, 0F3C, 4B41, 8C73, 00FF
  - ctrl2: 32320A5A, 5A0A0A5A, 32320A5A, 32320A5A, 32320A5A, 000A3232
- Other outputs at reset: o_wr_ready=1, o_commit_pending=0, o_commit_done=0, o_error=0, o_timeout=0, state IDLE, counter 0.
- Write handshake:
  - A write is accepted on an edge where i_wr_valid & o_wr_ready.
  - The shadow register updates at that edge.
  - An invalid address is still accepted; its data is dropped and o_error is set at that edge.
  - Writes never change o_ctrl1/o_ctrl2 directly.
- o_wr_ready = (state==IDLE), combinational from state. Writes are blocked while a commit is pending, which keeps the commit atomic.
- FSM:
  - IDLE: i_commit -> ARMED; counter <= 0.
    - A write and a commit accepted on the same edge: the write is included in the commit.
  - ARMED:
    - i_pipe_flush=1: hold. SOF is ignored and the counter is frozen.
    - Else i_sof=1 -> APPLY.
    - Else counter == SOF_TIMEOUT-1 -> APPLY, and o_timeout <= 1.
    - Else counter increments.
    - i_commit is ignored.
    - An SOF on the same cycle as the IDLE->ARMED commit is not used; only an SOF seen while in ARMED counts.
  - APPLY (one cycle): at the exiting edge, active <= shadow (all 12 words) and o_commit_done <= 1 for exactly one cycle; state -> IDLE.
- Latency:
  - SOF sampled in ARMED at edge N.
  - New o_ctrl values and o_commit_done are visible after edge N+1.
  - o_wr_ready returns to 1 after edge N+1.
- Reset mid-commit: asynchronous return to defaults and IDLE; the pending commit is discarded.
- Sticky flags clear only on reset.
- All outputs are registered except o_wr_ready and o_commit_pending, which decode state.

Test Plan:
- Reset release, no activity for 100 cycles -> o_ctrl1[15:0]=000A, o_ctrl2[191:160]=000A3232, o_wr_ready=1, all flags 0.
- Write addr 6 data 0000_5040, commit, SOF 10 cycles later -> o_ctrl1[63:48] unchanged until 2 edges after SOF, then 5040. o_commit_done high exactly 1 cycle. Other words unchanged.
- Commit pending with i_wr_valid held high -> o_wr_ready=0, no shadow change. The write is accepted on the cycle after o_commit_done, and the active value is unaffected until the next commit.
- SOF_TIMEOUT=16, commit with no SOF -> apply after 16 ARMED cycles, o_timeout=1. With i_pipe_flush high for 20 of those cycles and an SOF during the flush, the apply is delayed by 20 cycles.
- Write addr 13 -> accepted, o_error=1, banks unchanged. A subsequent valid write still works.
- Commit, then db_rstn asserted mid-ARMED -> outputs are immediately the defaults, state IDLE, no o_commit_done.
